// File: rtl/ad7124_result_bram_writer.sv
// Collects tagged AD7124 results into a ping-pong BRAM bank pair; on each frame
// boundary writes a {frame_count, beat_count} header, swaps banks and pulses irq.
module ad7124_result_bram_writer #(
  parameter int NUM_OF_CH       = 54,
  parameter int BANK_BYTES      = 512,
  parameter int BRAM_ADDR_WIDTH = 13
) (
  input  logic                       aclk,
  input  logic                       areset,
  input  logic                       enable,
  input  logic                       frame_start,
  input  logic                       clear_err,
  input  logic                       s_tvalid,
  output logic                       s_tready,
  input  logic [6:0]                 s_tchannel,
  input  logic [23:0]                s_tdata,
  input  logic [7:0]                 s_tstatus,
  output logic                       bram_clk,
  output logic                       bram_rst,
  output logic                       bram_en,
  output logic [3:0]                 bram_we,
  output logic [BRAM_ADDR_WIDTH-1:0] bram_addr,
  output logic [31:0]                bram_wrdata,
  output logic                       irq_pulse,
  output logic                       active_bank,
  output logic [15:0]                frame_count,
  output logic                       err_chan,
  output logic                       err_overrun
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_COLLECT,
    ST_HDR0,
    ST_HDR1,
    ST_SWAP
  } state_t;

  localparam logic [6:0]                 LP_NUM_CH    = 7'(NUM_OF_CH);
  localparam logic [BRAM_ADDR_WIDTH-1:0] LP_BANK_BASE = BRAM_ADDR_WIDTH'(BANK_BYTES);

  state_t                     r_state;
  state_t                     w_next_state;
  logic [7:0]                 r_beat_count;
  logic                       w_beat;
  logic                       w_chan_ok;
  logic                       w_wr;
  logic [7:0]                 w_word;
  logic [31:0]                w_data;
  logic [BRAM_ADDR_WIDTH-1:0] w_addr;
  logic                       w_swap;
  logic                       w_overrun;
  logic                       w_frame_open;

  assign bram_clk = aclk;
  assign bram_rst = areset;

  always_ff @(posedge aclk) begin
    if (areset) r_state <= ST_IDLE;
    else        r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    if (!enable) begin
      w_next_state = ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE:    if (frame_start) w_next_state = ST_COLLECT;
        ST_COLLECT: if (frame_start) w_next_state = ST_HDR0;
        ST_HDR0:    w_next_state = ST_HDR1;
        ST_HDR1:    w_next_state = ST_SWAP;
        ST_SWAP:    w_next_state = ST_COLLECT;
        default:    w_next_state = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    // NOTE: every combinational output gets a default first so no path infers a latch.
    s_tready  = (r_state == ST_COLLECT);
    w_beat    = s_tvalid && s_tready;
    w_chan_ok = (s_tchannel < LP_NUM_CH);
    w_wr      = 1'b0;
    w_word    = 8'd0;
    w_data    = 32'd0;
    case (r_state)
      ST_COLLECT: begin
        if (w_beat && w_chan_ok) begin
          w_wr   = 1'b1;
          w_word = {1'b0, s_tchannel} + 8'd2;
          w_data = {s_tstatus, s_tdata};
        end
      end
      ST_HDR0: begin
        w_wr   = enable;
        w_data = {16'h0, frame_count};
      end
      ST_HDR1: begin
        w_wr   = enable;
        w_word = 8'd1;
        w_data = {24'h0, r_beat_count};
      end
      default: ;
    endcase
    w_addr       = (active_bank ? LP_BANK_BASE : '0) + BRAM_ADDR_WIDTH'({w_word, 2'b00});
    w_swap       = (r_state == ST_SWAP) && enable;
    w_overrun    = frame_start &&
                   ((r_state == ST_HDR0) || (r_state == ST_HDR1) || (r_state == ST_SWAP));
    w_frame_open = (r_state == ST_IDLE) && (w_next_state == ST_COLLECT);
  end

  // NOTE: only control/status state is reset; BRAM contents written earlier stay as they are.
  always_ff @(posedge aclk) begin
    if (areset) begin
      bram_en      <= 1'b0;
      bram_we      <= 4'h0;
      bram_addr    <= '0;
      bram_wrdata  <= 32'd0;
      irq_pulse    <= 1'b0;
      active_bank  <= 1'b0;
      frame_count  <= 16'd0;
      r_beat_count <= 8'd0;
      err_chan     <= 1'b0;
      err_overrun  <= 1'b0;
    end else begin
      bram_en   <= w_wr;
      bram_we   <= {4{w_wr}};
      irq_pulse <= w_swap;
      if (w_wr) begin
        bram_addr   <= w_addr;
        bram_wrdata <= w_data;
      end
      if (w_swap) begin
        active_bank <= ~active_bank;
        frame_count <= frame_count + 16'd1;
      end
      if (w_swap || w_frame_open)
        r_beat_count <= 8'd0;
      else if (w_beat && w_chan_ok && (r_beat_count != 8'hFF))
        r_beat_count <= r_beat_count + 8'd1;
      // clear_err wins over a set landing in the same cycle
      if (clear_err)                    err_chan <= 1'b0;
      else if (w_beat && !w_chan_ok)    err_chan <= 1'b1;
      if (clear_err)                    err_overrun <= 1'b0;
      else if (w_overrun)               err_overrun <= 1'b1;
    end
  end

endmodule

// File: tb/tb_ad7124_result_bram_writer.sv
// Scoreboard bench for ad7124_result_bram_writer: expected BRAM writes are queued
// as stimulus is driven and popped by a negedge monitor as the DUT writes them.
module tb_ad7124_result_bram_writer;

  localparam int NCH = 54;
  localparam int BB  = 512;
  localparam int AW  = 13;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [31:0]   data;
  } wr_t;

  logic          aclk = 1'b0;
  logic          areset, enable, frame_start, clear_err, s_tvalid, s_tready;
  logic [6:0]    s_tchannel;
  logic [23:0]   s_tdata;
  logic [7:0]    s_tstatus;
  logic          bram_clk, bram_rst, bram_en;
  logic [3:0]    bram_we;
  logic [AW-1:0] bram_addr;
  logic [31:0]   bram_wrdata;
  logic          irq_pulse, active_bank, err_chan, err_overrun;
  logic [15:0]   frame_count;

  wr_t         sb[$];
  int          n_pass  = 0;
  int          n_total = 0;
  int          irq_cnt = 0;
  logic        m_bank  = 1'b0;
  logic [15:0] m_fc    = 16'd0;
  logic [7:0]  m_beats = 8'd0;

  ad7124_result_bram_writer #(.NUM_OF_CH(NCH), .BANK_BYTES(BB), .BRAM_ADDR_WIDTH(AW)) dut (
    .aclk(aclk), .areset(areset), .enable(enable), .frame_start(frame_start),
    .clear_err(clear_err), .s_tvalid(s_tvalid), .s_tready(s_tready),
    .s_tchannel(s_tchannel), .s_tdata(s_tdata), .s_tstatus(s_tstatus),
    .bram_clk(bram_clk), .bram_rst(bram_rst), .bram_en(bram_en), .bram_we(bram_we),
    .bram_addr(bram_addr), .bram_wrdata(bram_wrdata), .irq_pulse(irq_pulse),
    .active_bank(active_bank), .frame_count(frame_count),
    .err_chan(err_chan), .err_overrun(err_overrun)
  );

  always #5 aclk = ~aclk;

  function automatic logic [AW-1:0] exp_addr(input logic bank, input int word);
    return AW'(int'(bank) * BB + 4 * word);
  endfunction

  // Write monitor: every BRAM write must match the oldest expected write.
  always @(negedge aclk) begin
    if (irq_pulse === 1'b1) irq_cnt++;
    if (bram_en !== 1'b0) begin
      n_total++;
      if (sb.size() == 0) begin
        $display("FAIL unexpected_write: addr=0x%0h data=0x%08h en=%b, required no write",
                 bram_addr, bram_wrdata, bram_en);
      end else begin
        wr_t e;
        e = sb.pop_front();
        if (bram_addr !== e.addr || bram_wrdata !== e.data || bram_we !== 4'hF)
          $display("FAIL bram_write: got addr=0x%0h data=0x%08h we=%h, required addr=0x%0h data=0x%08h we=f",
                   bram_addr, bram_wrdata, bram_we, e.addr, e.data);
        else n_pass++;
      end
    end
  end

  task automatic tick();
    @(posedge aclk);
    #1;
  endtask

  task automatic push_beat(input logic [6:0] ch, input logic [23:0] d, input logic [7:0] st);
    if (int'(ch) < NCH) begin
      sb.push_back('{addr: exp_addr(m_bank, int'(ch) + 2), data: {st, d}});
      if (m_beats != 8'hFF) m_beats = m_beats + 8'd1;
    end
  endtask

  task automatic send_beat(input logic [6:0] ch, input logic [23:0] d, input logic [7:0] st);
    s_tvalid = 1'b1; s_tchannel = ch; s_tdata = d; s_tstatus = st;
    n_total++;
    if (s_tready !== 1'b1) $display("FAIL beat_ready: s_tready=%b, required 1", s_tready);
    else n_pass++;
    push_beat(ch, d, st);
    tick();
    s_tvalid = 1'b0;
  endtask

  task automatic expect_drained(input string name);
    tick(); tick();
    n_total++;
    if (sb.size() != 0) $display("FAIL %s_drain: %0d writes outstanding, required 0", name, sb.size());
    else n_pass++;
  endtask

  task automatic close_frame(input bit with_beat, input bit dbl_fs, input logic [6:0] ch,
                             input logic [23:0] d, input logic [7:0] st);
    int irq0;
    irq0 = irq_cnt;
    frame_start = 1'b1;
    if (with_beat) begin
      s_tvalid = 1'b1; s_tchannel = ch; s_tdata = d; s_tstatus = st;
      push_beat(ch, d, st);
    end
    sb.push_back('{addr: exp_addr(m_bank, 0), data: {16'h0, m_fc}});
    sb.push_back('{addr: exp_addr(m_bank, 1), data: {24'h0, m_beats}});
    tick();                                  // now T+1
    s_tvalid = 1'b0;
    frame_start = dbl_fs;
    n_total++;
    if (s_tready !== 1'b0) $display("FAIL hdr_ready: s_tready=%b, required 0", s_tready);
    else n_pass++;
    tick();                                  // T+2
    frame_start = 1'b0;
    tick();                                  // T+3
    n_total++;
    if (irq_pulse !== 1'b0) $display("FAIL irq_early: irq_pulse=%b, required 0", irq_pulse);
    else n_pass++;
    tick();                                  // T+4
    m_bank = ~m_bank; m_fc = m_fc + 16'd1; m_beats = 8'd0;
    n_total++;
    if (irq_pulse !== 1'b1 || active_bank !== m_bank || frame_count !== m_fc || s_tready !== 1'b1)
      $display("FAIL swap: irq=%b bank=%b fc=%0d ready=%b, required irq=1 bank=%b fc=%0d ready=1",
               irq_pulse, active_bank, frame_count, s_tready, m_bank, m_fc);
    else n_pass++;
    tick();                                  // T+5
    n_total++;
    if (irq_pulse !== 1'b0 || irq_cnt - irq0 != 1)
      $display("FAIL irq_once: irq=%b pulses=%0d, required irq=0 pulses=1", irq_pulse, irq_cnt - irq0);
    else n_pass++;
    expect_drained("close");
  endtask

  task automatic test_reset();
    areset = 1'b1; enable = 1'b0; frame_start = 1'b0; clear_err = 1'b0;
    s_tvalid = 1'b0; s_tchannel = '0; s_tdata = '0; s_tstatus = '0;
    tick(); tick(); tick();
    n_total++;
    if (s_tready !== 1'b0 || bram_en !== 1'b0 || bram_we !== 4'h0 || bram_addr !== '0 ||
        bram_wrdata !== 32'd0 || irq_pulse !== 1'b0 || active_bank !== 1'b0 ||
        frame_count !== 16'd0 || err_chan !== 1'b0 || err_overrun !== 1'b0)
      $display("FAIL reset_values: ready=%b en=%b we=%h addr=%h wd=%h irq=%b bank=%b fc=%h ec=%b eo=%b, required all 0",
               s_tready, bram_en, bram_we, bram_addr, bram_wrdata, irq_pulse, active_bank,
               frame_count, err_chan, err_overrun);
    else n_pass++;
    areset = 1'b0;
    tick();
  endtask

  task automatic test_full_frame();
    enable = 1'b1;
    tick();
    n_total++;
    if (s_tready !== 1'b0) $display("FAIL idle_ready: s_tready=%b, required 0", s_tready);
    else n_pass++;
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    m_beats = 8'd0;
    for (int ch = 0; ch < NCH; ch++) send_beat(7'(ch), 24'h000100 + 24'(ch), 8'h80);
    expect_drained("full_frame");
    close_frame(1'b0, 1'b0, '0, '0, '0);
  endtask

  task automatic test_second_frame();
    for (int ch = 0; ch < 3; ch++) send_beat(7'(ch), 24'($urandom), 8'($urandom));
    close_frame(1'b0, 1'b0, '0, '0, '0);
    n_total++;
    if (active_bank !== 1'b0 || frame_count !== 16'd2)
      $display("FAIL second_frame: bank=%b fc=%0d, required bank=0 fc=2", active_bank, frame_count);
    else n_pass++;
  endtask

  task automatic test_bad_channel();
    send_beat(7'd60, 24'hABCDEF, 8'h11);
    n_total++;
    if (err_chan !== 1'b1) $display("FAIL err_chan_set: err_chan=%b, required 1", err_chan);
    else n_pass++;
    clear_err = 1'b1;
    tick();
    clear_err = 1'b0;
    n_total++;
    if (err_chan !== 1'b0) $display("FAIL err_chan_clear: err_chan=%b, required 0", err_chan);
    else n_pass++;
    clear_err = 1'b1;
    send_beat(7'd127, 24'h123456, 8'h22);
    clear_err = 1'b0;
    n_total++;
    if (err_chan !== 1'b0) $display("FAIL err_chan_priority: err_chan=%b, required 0", err_chan);
    else n_pass++;
    send_beat(7'd53, 24'h0F0F0F, 8'h53);
    expect_drained("bad_channel");
  endtask

  task automatic test_back_to_back();
    send_beat(7'd7, 24'h777777, 8'h07);
    close_frame(1'b1, 1'b0, 7'd9, 24'h999999, 8'h09);
  endtask

  task automatic test_overrun();
    send_beat(7'd1, 24'h010101, 8'h01);
    send_beat(7'd1, 24'h020202, 8'h02);
    close_frame(1'b0, 1'b1, '0, '0, '0);
    n_total++;
    if (err_overrun !== 1'b1) $display("FAIL err_overrun_set: err_overrun=%b, required 1", err_overrun);
    else n_pass++;
    clear_err = 1'b1;
    tick();
    clear_err = 1'b0;
    n_total++;
    if (err_overrun !== 1'b0) $display("FAIL err_overrun_clear: err_overrun=%b, required 0", err_overrun);
    else n_pass++;
  endtask

  task automatic test_saturation();
    for (int i = 0; i < 260; i++) send_beat(7'(i % NCH), 24'(i), 8'(i));
    close_frame(1'b0, 1'b0, '0, '0, '0);
  endtask

  task automatic test_enable_drop();
    int irq0;
    irq0 = irq_cnt;
    send_beat(7'd3, 24'h333333, 8'h33);
    enable = 1'b0;
    tick();
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    enable = 1'b1;
    tick(); tick(); tick();
    n_total++;
    if (s_tready !== 1'b0 || irq_cnt != irq0 || active_bank !== m_bank || frame_count !== m_fc)
      $display("FAIL enable_drop: ready=%b irqs=%0d bank=%b fc=%0d, required ready=0 irqs=0 bank=%b fc=%0d",
               s_tready, irq_cnt - irq0, active_bank, frame_count, m_bank, m_fc);
    else n_pass++;
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    m_beats = 8'd0;
    send_beat(7'd5, 24'h555555, 8'h55);
    expect_drained("resume");
  endtask

  task automatic test_reset_mid_frame();
    int irq0;
    irq0 = irq_cnt;
    send_beat(7'd4, 24'h444444, 8'h44);
    areset = 1'b1;
    tick(); tick();
    areset = 1'b0;
    m_bank = 1'b0; m_fc = 16'd0; m_beats = 8'd0;
    tick(); tick(); tick();
    n_total++;
    if (s_tready !== 1'b0 || irq_cnt != irq0 || active_bank !== 1'b0 || frame_count !== 16'd0)
      $display("FAIL reset_mid: ready=%b irqs=%0d bank=%b fc=%0d, required ready=0 irqs=0 bank=0 fc=0",
               s_tready, irq_cnt - irq0, active_bank, frame_count);
    else n_pass++;
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    send_beat(7'd0, 24'hC0FFEE, 8'h5A);
    close_frame(1'b0, 1'b0, '0, '0, '0);
  endtask

  initial begin
    test_reset();
    test_full_frame();
    test_second_frame();
    test_bad_channel();
    test_back_to_back();
    test_overrun();
    test_saturation();
    test_enable_drop();
    test_reset_mid_frame();
    expect_drained("final");
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
